// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one single-outstanding memory port: IDLE -> ISSUE -> WAIT -> RESP.
// Optional fetch anti-starvation counter is enabled by defining MEM_ARBITER_FAIRNESS_EN.
module mem_arbiter #(
  parameter int unsigned LAT      = 1,
  parameter int unsigned MAX_SKIP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        m_en_o,
  output logic        m_we_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  input  logic [31:0] m_rdata_i,
  output logic        busy_o,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a requester holds req/addr/data stable until its one-cycle gnt pulse;
  // the matching rvalid pulse follows exactly LAT cycles after gnt, one access in flight.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_CYCLES = 4'(LAT - 1);

  if (LAT < 1 || LAT > 15) begin : g_bad_lat
    $error("mem_arbiter: LAT must be within 1..15");
  end
  if (MAX_SKIP < 1 || MAX_SKIP > 15) begin : g_bad_skip
    $error("mem_arbiter: MAX_SKIP must be within 1..15");
  end

  state_t      state_q;
  logic        sel_data_q;
  logic        we_q;
  logic [3:0]  wait_cnt_q;
  logic        if_gnt_q;
  logic        d_gnt_q;
  logic        if_rvalid_q;
  logic        d_rvalid_q;
  logic        m_en_q;
  logic        m_we_q;
  logic [31:0] m_addr_q;
  logic [31:0] m_wdata_q;

  logic any_req;
  logic pick_data;

  assign any_req = if_req_i | d_req_i;

`ifdef MEM_ARBITER_FAIRNESS_EN
  localparam logic [3:0] SKIP_LIMIT = 4'(MAX_SKIP);
  logic [3:0] skip_q;
  logic       fetch_turn;

  // Once fetch has been passed over SKIP_LIMIT times in a row it takes the next slot.
  assign fetch_turn = if_req_i && (skip_q == SKIP_LIMIT);
  assign pick_data  = d_req_i && !fetch_turn;
`else
  assign pick_data  = d_req_i;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_data_q  <= 1'b0;
      we_q        <= 1'b0;
      wait_cnt_q  <= 4'd0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      m_en_q      <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= 32'd0;
      m_wdata_q   <= 32'd0;
`ifdef MEM_ARBITER_FAIRNESS_EN
      skip_q      <= 4'd0;
`endif
    end else begin
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      m_en_q      <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= 32'd0;
      m_wdata_q   <= 32'd0;
      case (state_q)
        IDLE, RESP: begin
          if (any_req) begin
            state_q    <= ISSUE;
            sel_data_q <= pick_data;
            we_q       <= pick_data & d_we_i;
            m_en_q     <= 1'b1;
            m_we_q     <= pick_data & d_we_i;
            m_addr_q   <= pick_data ? d_addr_i : if_addr_i;
            m_wdata_q  <= pick_data ? d_wdata_i : 32'd0;
            d_gnt_q    <= pick_data;
            if_gnt_q   <= !pick_data;
`ifdef MEM_ARBITER_FAIRNESS_EN
            if (!pick_data) begin
              skip_q <= 4'd0;
            end else if (if_req_i) begin
              skip_q <= skip_q + 4'd1;
            end
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          if (LAT == 1) begin
            state_q     <= RESP;
            if_rvalid_q <= !sel_data_q;
            d_rvalid_q  <= sel_data_q;
          end else begin
            state_q    <= WAIT;
            wait_cnt_q <= WAIT_CYCLES;
          end
        end
        WAIT: begin
          if (wait_cnt_q == 4'd1) begin
            state_q     <= RESP;
            if_rvalid_q <= !sel_data_q;
            d_rvalid_q  <= sel_data_q;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_gnt_o    = if_gnt_q;
  assign d_gnt_o     = d_gnt_q;
  assign if_rvalid_o = if_rvalid_q;
  assign d_rvalid_o  = d_rvalid_q;
  assign m_en_o      = m_en_q;
  assign m_we_o      = m_we_q;
  assign m_addr_o    = m_addr_q;
  assign m_wdata_o   = m_wdata_q;
  // Read data passes straight from memory in the RESP cycle; writes complete with zero data.
  assign if_rdata_o  = if_rvalid_q ? m_rdata_i : 32'd0;
  assign d_rdata_o   = (d_rvalid_q && !we_q) ? m_rdata_i : 32'd0;
  assign busy_o      = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (LAT=2, MAX_SKIP=2): directed scenarios plus a
// randomized run against a transaction-level schedule model.
module tb_mem_arbiter;

  localparam int LAT      = 2;
  localparam int MAX_SKIP = 2;
  localparam int N_RAND   = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        m_en_o;
  logic        m_we_o;
  logic [31:0] m_addr_o;
  logic [31:0] m_wdata_o;
  logic [31:0] m_rdata_i;
  logic        busy_o;
  logic [1:0]  dbg_state_o;

  int tests = 0;
  int fails = 0;

  logic [6:0] ctl_w;
  assign ctl_w = {if_gnt_o, d_gnt_o, m_en_o, m_we_o, if_rvalid_o, d_rvalid_o, busy_o};

  always #5 clk = ~clk;

  mem_arbiter #(.LAT(LAT), .MAX_SKIP(MAX_SKIP)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .m_en_o(m_en_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_rdata_i(m_rdata_i), .busy_o(busy_o), .dbg_state_o(dbg_state_o)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Leaves the bench at a falling edge with rst low: that is cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    if_req_i = 1'b0; if_addr_i = 32'd0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = 32'd0; d_wdata_i = 32'd0;
    m_rdata_i = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req_i = 1'b1; if_addr_i = $urandom();
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = $urandom(); d_wdata_i = $urandom();
    m_rdata_i = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    tests++;
    if (ctl_w !== 7'd0) begin
      fails++; $display("FAIL reset_ctl got=%b exp=%b", ctl_w, 7'd0);
    end
    tests++;
    if ({m_addr_o, m_wdata_o} !== 64'd0) begin
      fails++; $display("FAIL reset_bus got=%h/%h exp=0/0", m_addr_o, m_wdata_o);
    end
    tests++;
    if ({if_rdata_o, d_rdata_o} !== 64'd0) begin
      fails++; $display("FAIL reset_rdata got=%h/%h exp=0/0", if_rdata_o, d_rdata_o);
    end
  endtask

  task automatic test_fetch_read();
    logic [6:0]  exp_ctl;
    logic [31:0] exp_addr, exp_rd;
    do_reset();
    if_req_i = 1'b1; if_addr_i = 32'h10; m_rdata_i = 32'hDEADBEEF;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      exp_ctl  = (c == 1) ? 7'b1010001 : (c == 2) ? 7'b0000001 : (c == 3) ? 7'b0000101 : 7'b0000000;
      exp_addr = (c == 1) ? 32'h10 : 32'd0;
      exp_rd   = (c == 3) ? 32'hDEADBEEF : 32'd0;
      tests++;
      if (ctl_w !== exp_ctl) begin
        fails++; $display("FAIL fetch_ctl cyc=%0d got=%b exp=%b", c, ctl_w, exp_ctl);
      end
      tests++;
      if (m_addr_o !== exp_addr) begin
        fails++; $display("FAIL fetch_addr cyc=%0d got=%h exp=%h", c, m_addr_o, exp_addr);
      end
      tests++;
      if (if_rdata_o !== exp_rd) begin
        fails++; $display("FAIL fetch_rdata cyc=%0d got=%h exp=%h", c, if_rdata_o, exp_rd);
      end
      if (c == 1) if_req_i = 1'b0;
    end
  endtask

  task automatic test_write_then_fetch();
    logic [6:0]  exp_ctl;
    logic [31:0] exp_addr, exp_wd, exp_if_rd;
    do_reset();
    if_req_i = 1'b1; if_addr_i = 32'h10;
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h20; d_wdata_i = 32'h55;
    m_rdata_i = 32'hDEADBEEF;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      case (c)
        1: exp_ctl = 7'b0111001;
        3: exp_ctl = 7'b0000011;
        4: exp_ctl = 7'b1010001;
        6: exp_ctl = 7'b0000101;
        7: exp_ctl = 7'b0000000;
        default: exp_ctl = 7'b0000001;
      endcase
      exp_addr  = (c == 1) ? 32'h20 : (c == 4) ? 32'h10 : 32'd0;
      exp_wd    = (c == 1) ? 32'h55 : 32'd0;
      exp_if_rd = (c == 6) ? 32'hDEADBEEF : 32'd0;
      tests++;
      if (ctl_w !== exp_ctl) begin
        fails++; $display("FAIL wr_fetch_ctl cyc=%0d got=%b exp=%b", c, ctl_w, exp_ctl);
      end
      tests++;
      if ({m_addr_o, m_wdata_o} !== {exp_addr, exp_wd}) begin
        fails++; $display("FAIL wr_fetch_bus cyc=%0d got=%h/%h exp=%h/%h", c, m_addr_o, m_wdata_o, exp_addr, exp_wd);
      end
      tests++;
      if ({d_rdata_o, if_rdata_o} !== {32'd0, exp_if_rd}) begin
        fails++; $display("FAIL wr_fetch_rdata cyc=%0d got=%h/%h exp=0/%h", c, d_rdata_o, if_rdata_o, exp_if_rd);
      end
      if (c == 1) d_req_i = 1'b0;
      if (c == 4) if_req_i = 1'b0;
    end
  endtask

  task automatic test_contention();
    logic exp_d, exp_if;
    do_reset();
    if_req_i = 1'b1; if_addr_i = 32'h100;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h200; d_wdata_i = 32'd0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      m_rdata_i = $urandom();
      exp_d = 1'b0; exp_if = 1'b0;
      if (c % 3 == 1) begin
`ifdef MEM_ARBITER_FAIRNESS_EN
        exp_if = (((c - 1) / 3) % 3 == 2);
`else
        exp_if = 1'b0;
`endif
        exp_d = !exp_if;
      end
      tests++;
      if ({if_gnt_o, d_gnt_o} !== {exp_if, exp_d}) begin
        fails++; $display("FAIL contention_gnt cyc=%0d got=%b%b exp=%b%b", c, if_gnt_o, d_gnt_o, exp_if, exp_d);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    logic [6:0] exp_ctl;
    do_reset();
    if_req_i = 1'b1; if_addr_i = 32'h40; m_rdata_i = 32'h12345678;
    @(negedge clk);
    tests++;
    if (ctl_w !== 7'b1010001) begin
      fails++; $display("FAIL midrst_issue got=%b exp=%b", ctl_w, 7'b1010001);
    end
    if_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h80; d_wdata_i = 32'hA5;
    #1;
    tests++;
    if ({ctl_w, m_addr_o, if_rdata_o, d_rdata_o} !== 103'd0) begin
      fails++; $display("FAIL midrst_assert got=%b/%h/%h exp=0", ctl_w, m_addr_o, if_rdata_o);
    end
    @(negedge clk);
    tests++;
    if ({ctl_w, if_rdata_o} !== 39'd0) begin
      fails++; $display("FAIL midrst_held got=%b/%h exp=0", ctl_w, if_rdata_o);
    end
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      exp_ctl = (c == 1) ? 7'b0110001 : (c == 2) ? 7'b0000001 : (c == 3) ? 7'b0000011 : 7'b0000000;
      tests++;
      if (ctl_w !== exp_ctl) begin
        fails++; $display("FAIL midrst_after cyc=%0d got=%b exp=%b", c, ctl_w, exp_ctl);
      end
      if (c == 1) begin
        d_req_i = 1'b0;
        tests++;
        if (m_addr_o !== 32'h80) begin
          fails++; $display("FAIL midrst_addr got=%h exp=%h", m_addr_o, 32'h80);
        end
      end
      if (c == 3) begin
        tests++;
        if (d_rdata_o !== 32'h12345678) begin
          fails++; $display("FAIL midrst_rdata got=%h exp=%h", d_rdata_o, 32'h12345678);
        end
      end
    end
  endtask

  // Model: each decision at cycle c books gnt at c+1, rvalid at c+1+LAT, next decision at c+1+LAT.
  task automatic test_random();
    bit          en_h[N_RAND];
    logic [31:0] addr_h[N_RAND];
    int          next_dec, cur_gnt, cur_rv, skip;
    bit          cur_valid, cur_data, cur_we, if_pend, d_pend, g, r, win_d;
    logic [31:0] cur_addr, cur_wdata, pf_addr, pd_addr, pd_wdata;
    bit          pd_we;
    logic [6:0]  exp_ctl;
    logic [31:0] exp_addr, exp_wd, exp_if_rd, exp_d_rd;
    do_reset();
    next_dec = 0; cur_valid = 0; cur_gnt = 0; cur_rv = 0; skip = 0;
    cur_data = 0; cur_we = 0; cur_addr = 0; cur_wdata = 0;
    if_pend = 0; d_pend = 0; pf_addr = 0; pd_addr = 0; pd_wdata = 0; pd_we = 0;
    for (int c = 0; c < N_RAND; c++) begin
      if (c > 0) @(negedge clk);
      en_h[c] = m_en_o; addr_h[c] = m_addr_o;
      m_rdata_i = (c >= LAT && en_h[c-LAT]) ? mem_word(addr_h[c-LAT]) : $urandom();
      #1;
      g = cur_valid && (cur_gnt == c);
      r = cur_valid && (cur_rv == c);
      exp_ctl = {g && !cur_data, g && cur_data, g, g && cur_we, r && !cur_data, r && cur_data,
                 cur_valid && c >= cur_gnt && c <= cur_rv};
      exp_addr  = g ? cur_addr : 32'd0;
      exp_wd    = (g && cur_data) ? cur_wdata : 32'd0;
      exp_if_rd = (r && !cur_data) ? mem_word(cur_addr) : 32'd0;
      exp_d_rd  = (r && cur_data && !cur_we) ? mem_word(cur_addr) : 32'd0;
      tests++;
      if (ctl_w !== exp_ctl) begin
        fails++; $display("FAIL rand_ctl cyc=%0d got=%b exp=%b", c, ctl_w, exp_ctl);
      end
      tests++;
      if (m_addr_o !== exp_addr) begin
        fails++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", c, m_addr_o, exp_addr);
      end
      tests++;
      if (m_wdata_o !== exp_wd) begin
        fails++; $display("FAIL rand_wdata cyc=%0d got=%h exp=%h", c, m_wdata_o, exp_wd);
      end
      tests++;
      if ({if_rdata_o, d_rdata_o} !== {exp_if_rd, exp_d_rd}) begin
        fails++; $display("FAIL rand_rdata cyc=%0d got=%h/%h exp=%h/%h", c, if_rdata_o, d_rdata_o, exp_if_rd, exp_d_rd);
      end
      if (g && cur_data) d_pend = 0;
      if (g && !cur_data) if_pend = 0;
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1; pf_addr = $urandom();
      end
      if (!d_pend && $urandom_range(0, 1) == 0) begin
        d_pend = 1; pd_addr = $urandom(); pd_wdata = $urandom(); pd_we = $urandom_range(0, 1) == 1;
      end
      if_req_i = if_pend; if_addr_i = pf_addr;
      d_req_i = d_pend; d_addr_i = pd_addr; d_wdata_i = pd_wdata; d_we_i = pd_we;
      if (c == next_dec) begin
        if (if_pend || d_pend) begin
`ifdef MEM_ARBITER_FAIRNESS_EN
          win_d = d_pend && !(if_pend && skip == MAX_SKIP);
          if (!win_d) skip = 0;
          else if (if_pend) skip++;
`else
          win_d = d_pend;
`endif
          cur_valid = 1; cur_data = win_d; cur_we = win_d && pd_we;
          cur_addr = win_d ? pd_addr : pf_addr; cur_wdata = pd_wdata;
          cur_gnt = c + 1; cur_rv = c + 1 + LAT; next_dec = c + 1 + LAT;
        end else begin
          next_dec = c + 1;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_write_then_fetch();
    test_contention();
    test_reset_mid_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LAT, default 1, memory read latency in cycles from the m_en_o cycle to valid m_rdata_i; legal range 1..15.
REQ-002 Parameter MAX_SKIP, default 4, maximum consecutive data grants while fetch waits; legal range 1..15.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 if_req_i  in  1  fetch request; held with if_addr_i stable until if_gnt_o.
REQ-006 if_addr_i  in  32  fetch address.
REQ-007 if_gnt_o  out  1  one-cycle pulse: fetch access issued.
REQ-008 if_rvalid_o / if_rdata_o  out  1/32  fetch response strobe and read data.
REQ-009 d_req_i, d_we_i  in  1,1  data request (held until d_gnt_o), 1 = write.
REQ-010 d_addr_i, d_wdata_i  in  32,32  data address and write data.
REQ-011 d_gnt_o  out  1  one-cycle pulse: data access issued.
REQ-012 d_rvalid_o / d_rdata_o  out  1/32  data completion strobe (reads and writes) and read data.
REQ-013 m_en_o, m_we_o  out  1,1  shared memory enable and write enable.
REQ-014 m_addr_o, m_wdata_o  out  32,32  shared memory address and write data.
REQ-015 m_rdata_i  in  32  shared memory read data.
REQ-016 busy_o  out  1  high whenever FSM is not IDLE.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, RESP; at most one access is outstanding.
REQ-018 Arbitration is evaluated only in IDLE and RESP; requests in ISSUE and WAIT are ignored.
REQ-019 IDLE or RESP with any request -> ISSUE; the winner's addr/we/wdata are registered on that edge; RESP with no request -> IDLE.
REQ-020 ISSUE lasts 1 cycle: m_en_o=1, m_addr_o/m_we_o/m_wdata_o = latched values, winner's gnt_o=1.
REQ-021 ISSUE -> RESP if LAT=1, else ISSUE -> WAIT for exactly LAT-1 cycles (4-bit down-counter), then RESP.
REQ-022 RESP lasts 1 cycle: winner's rvalid_o=1; rdata_o = m_rdata_i for reads, 0 for writes.
REQ-023 rdata_o SHALL be 0 whenever rvalid_o is 0; gnt and rvalid SHALL never be asserted to both requesters in one cycle.
REQ-024 Fetch requests are always reads; m_we_o=0 for fetch accesses.
REQ-025 Default priority: data wins over fetch when both request.
REQ-026 Back-to-back: a request held high through RESP is issued in the cycle after RESP (throughput one access per LAT+2 cycles from IDLE, LAT+1 back-to-back).
REQ-027 m_we_o, m_addr_o, m_wdata_o SHALL be 0 outside ISSUE.

Reset
REQ-028 rst asserted, at any time including mid-access: FSM -> IDLE immediately, all outputs 0, skip counter 0, in-flight access dropped with no rvalid.
REQ-029 First arbitration occurs on the first rising edge after rst deasserts.

Configuration
REQ-030 Macro MEM_ARBITER_FAIRNESS_EN defined: a 4-bit skip counter increments on each data grant made while if_req_i=1, clears on each fetch grant; when it equals MAX_SKIP and both request, fetch wins.
REQ-031 Macro undefined: no skip counter; strict data priority, fetch may starve indefinitely.

Verification (LAT=2, MAX_SKIP=2, cycle 0 = first cycle after reset)
REQ-032 if_req_i=1, if_addr_i=0x10 at cycle 0; m_rdata_i=0xDEADBEEF -> m_en_o, if_gnt_o, m_addr_o=0x10 at cycle 1; if_rvalid_o=1, if_rdata_o=0xDEADBEEF at cycle 3; busy_o 1 in cycles 1-3.
REQ-033 Both request at cycle 0, d_we_i=1, d_addr_i=0x20, d_wdata_i=0x55 -> d_gnt_o, m_we_o=1, m_wdata_o=0x55 at cycle 1; d_rvalid_o, d_rdata_o=0 at cycle 3; if_gnt_o at cycle 4.
REQ-034 FAIRNESS_EN, both held high continuously -> grants d (cycle 1), d (cycle 4), if (cycle 7), d (cycle 10).
REQ-035 FAIRNESS_EN undefined, both held high for 20 cycles -> d_gnt_o at cycles 1,4,7,...; if_gnt_o never asserted.
REQ-036 Read issued at cycle 1, rst pulsed in cycle 2 (WAIT) -> all outputs 0 from reset assertion, no rvalid in cycle 3, busy_o=0, new access issued only after rst deasserts.
